// File: rtl/ultrasonic_pkg.sv
// Shared FSM encoding and 12 MHz default timing for the ultrasonic scanner.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DIVIDE,
    ST_PUBLISH,
    ST_COOLDOWN
  } state_t;

  localparam int unsigned DEF_NUM_CH          = 4;
  localparam int unsigned DEF_TRIG_CYCLES     = 120;     // 10 us
  localparam int unsigned DEF_CM_DIVISOR      = 696;     // echo cycles per cm
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 360000;  // 30 ms
  localparam int unsigned DEF_COOLDOWN_CYCLES = 120000;  // 10 ms
  localparam int unsigned DEF_CNT_W           = 24;
  localparam int unsigned DEF_DIST_W          = 16;

  // Timeout sentinel: all ones, truncated to the distance width by the user.
  localparam logic [31:0] TIMEOUT_DIST = 32'hFFFF_FFFF;

endpackage

// File: rtl/ultrasonic_scanner_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses W cycles after start.
module seq_divider #(
  parameter int unsigned W = 24
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quotient,
  output logic         o_done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic          w_ge;

  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ge    = (w_shift >= {1'b0, r_div});

  // Shift-subtract iteration; remainder always stays below the divisor so W bits suffice.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem <= '0;
        r_quo <= i_dividend;
        r_div <= i_divisor;
        r_cnt <= CW'(W);
      end else if (r_cnt != '0) begin
        r_rem <= w_ge ? W'(w_diff) : W'(w_shift);
        r_quo <= {r_quo[W-2:0], w_ge};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_done;

endmodule

// File: rtl/ultrasonic_scanner.sv
// Round-robin multi-channel ultrasonic ranger with timeout, saturation and per-channel result bank.
module ultrasonic_scanner
  import ultrasonic_pkg::*;
#(
  parameter int unsigned NUM_CH          = DEF_NUM_CH,
  parameter int unsigned TRIG_CYCLES     = DEF_TRIG_CYCLES,
  parameter int unsigned CM_DIVISOR      = DEF_CM_DIVISOR,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DIST_W          = DEF_DIST_W
) (
  input  logic                       i_hw_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic [NUM_CH-1:0]          i_echo,
  output logic [NUM_CH-1:0]          o_trig,
  output logic [NUM_CH*DIST_W-1:0]   o_ch_dist,
  output logic [NUM_CH-1:0]          o_ch_timeout,
  output logic                       o_res_valid,
  output logic [2:0]                 o_res_ch,
  output logic [DIST_W-1:0]          o_res_dist,
  output logic                       o_busy
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIST_W-1:0] SENTINEL = DIST_W'(TIMEOUT_DIST);

  state_t                     r_state;
  logic [PTR_W-1:0]           r_ptr;
  logic [CNT_W-1:0]           r_cnt;
  logic [NUM_CH-1:0]          r_trig;
  logic [NUM_CH*DIST_W-1:0]   r_ch_dist;
  logic [NUM_CH-1:0]          r_ch_timeout;
  logic                       r_res_valid;
  logic [2:0]                 r_res_ch;
  logic [DIST_W-1:0]          r_res_dist;
  logic                       r_busy;
  logic [DIST_W-1:0]          r_pub_dist;
  logic                       r_pub_to;
  logic                       r_div_start;

  logic [NUM_CH-1:0]          r_sync1;
  logic [NUM_CH-1:0]          r_sync2;
  logic [NUM_CH-1:0]          r_echo_d;

  logic                       w_echo;
  logic                       w_rise;
  logic [PTR_W-1:0]           w_ptr_next;
  logic [CNT_W-1:0]           w_quo;
  logic                       w_div_done;
  logic                       w_sat;
  logic [DIST_W-1:0]          w_dist;

  // Two-stage synchroniser plus one delay stage for edge detection on every channel.
  always_ff @(posedge i_hw_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_echo_d <= '0;
    end else begin
      r_sync1  <= i_echo;
      r_sync2  <= r_sync1;
      r_echo_d <= r_sync2;
    end
  end

  assign w_echo     = r_sync2[r_ptr];
  assign w_rise     = r_sync2[r_ptr] & ~r_echo_d[r_ptr];
  assign w_ptr_next = (r_ptr == PTR_W'(NUM_CH - 1)) ? '0 : PTR_W'(r_ptr + PTR_W'(1));

  seq_divider #(.W(CNT_W)) u_div (
    .i_clk      (i_hw_clk),
    .i_rst      (i_rst),
    .i_start    (r_div_start),
    .i_dividend (r_cnt),
    .i_divisor  (CNT_W'(CM_DIVISOR)),
    .o_quotient (w_quo),
    .o_done     (w_div_done)
  );

  assign w_sat  = (CNT_W > DIST_W) && ((w_quo >> DIST_W) != '0);
  assign w_dist = w_sat ? '1 : DIST_W'(w_quo);

  // Scan sequencer: trigger, wait for echo, measure, divide, publish, cool down, advance.
  always_ff @(posedge i_hw_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_trig       <= '0;
      r_ch_dist    <= '0;
      r_ch_timeout <= '0;
      r_res_valid  <= 1'b0;
      r_res_ch     <= '0;
      r_res_dist   <= '0;
      r_busy       <= 1'b0;
      r_pub_dist   <= '0;
      r_pub_to     <= 1'b0;
      r_div_start  <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state <= ST_TRIG;
            r_trig  <= NUM_CH'(1) << r_ptr;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_TRIG: begin
          if (r_cnt == CNT_W'(TRIG_CYCLES - 1)) begin
            r_trig  <= '0;
            r_cnt   <= '0;
            r_state <= ST_WAIT_RISE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_state <= ST_MEASURE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_pub_dist <= SENTINEL;
            r_pub_to   <= 1'b1;
            r_state    <= ST_PUBLISH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          // Falling echo leaves the width frozen in r_cnt as the divider's dividend.
          if (!w_echo) begin
            r_div_start <= 1'b1;
            r_state     <= ST_DIVIDE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_pub_dist <= SENTINEL;
            r_pub_to   <= 1'b1;
            r_state    <= ST_PUBLISH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            r_pub_dist <= w_dist;
            r_pub_to   <= 1'b0;
            r_state    <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          r_ch_dist[r_ptr*DIST_W +: DIST_W] <= r_pub_dist;
          r_ch_timeout[r_ptr]               <= r_pub_to;
          r_res_valid                       <= 1'b1;
          r_res_ch                          <= 3'(r_ptr);
          r_res_dist                        <= r_pub_dist;
          r_cnt                             <= '0;
          r_state                           <= ST_COOLDOWN;
        end
        ST_COOLDOWN: begin
          // Enable is only sampled here, so a started channel always completes.
          if (r_cnt == CNT_W'(COOLDOWN_CYCLES - 1)) begin
            r_ptr <= w_ptr_next;
            r_cnt <= '0;
            if (i_enable) begin
              r_state <= ST_TRIG;
              r_trig  <= NUM_CH'(1) << w_ptr_next;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_trig  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_trig       = r_trig;
  assign o_ch_dist    = r_ch_dist;
  assign o_ch_timeout = r_ch_timeout;
  assign o_res_valid  = r_res_valid;
  assign o_res_ch     = r_res_ch;
  assign o_res_dist   = r_res_dist;
  assign o_busy       = r_busy;

endmodule
